// File: rtl/ysyx_22050612_mdu_pkg.sv
// Shared types for the RV64M multiply/divide unit: opcodes, FSM states, W-op width.
// No logic; nothing to time.
// Imported by ysyx_22050612_mdu and ysyx_22050612_mdu_divcore.
package ysyx_22050612_mdu_pkg;

    typedef enum logic [3:0] {
        MUL    = 4'd0,
        MULH   = 4'd1,
        MULHSU = 4'd2,
        MULHU  = 4'd3,
        DIV    = 4'd4,
        DIVU   = 4'd5,
        REM    = 4'd6,
        REMU   = 4'd7,
        MULW   = 4'd8,
        DIVW   = 4'd9,
        DIVUW  = 4'd10,
        REMW   = 4'd11,
        REMUW  = 4'd12
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam int MDU_W_LEN = 32;

endpackage

// File: rtl/ysyx_22050612_mdu_divcore.sv
// Unsigned radix-2 restoring shift-subtract divider iteration, shared by all divide ops.
// One quotient bit per step; after N steps quo/rem hold the result (dividend pre-aligned to MSB).
// No handshake: caller issues start once and step per iteration.
// Ports: clk, rst_n (sync, active-low); start loads dividend/divisor; step runs one iteration;
//        quo/rem are the running quotient and partial remainder.
module ysyx_22050612_mdu_divcore #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    logic [XLEN-1:0] dvsr_q;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;
    logic            ge;

    // Dividend bits are shifted out of the top of quo while quotient bits enter at the bottom.
    always_comb begin
        trial = {rem, quo[XLEN-1]};
        diff  = trial - {1'b0, dvsr_q};
        ge    = ~diff[XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo    <= '0;
            rem    <= '0;
            dvsr_q <= '0;
        end else if (start) begin
            quo    <= dividend;
            rem    <= '0;
            dvsr_q <= divisor;
        end else if (step) begin
            quo <= {quo[XLEN-2:0], ge};
            // rem < divisor is invariant, so the difference always fits in XLEN bits.
            rem <= ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
        end
    end

endmodule

// File: rtl/ysyx_22050612_mdu.sv
// Multi-cycle RV64M multiply/divide unit beside the EXU ALU (valid/ready in, valid/ready out).
// Latency: N+1 cycles (N=32 for W ops, XLEN otherwise); div-by-zero/overflow in 1 cycle.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush aborts.
// Optional macro MDU_FAST_MUL_EN: single-cycle array multiply (multiply ops complete in 1 cycle).
// Ports: clk, rst_n (sync, active-low), flush, in_valid/in_ready/in_op/in_src1/in_src2/in_tag,
//        out_valid/out_ready/out_result/out_tag.
module ysyx_22050612_mdu
    import ysyx_22050612_mdu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(XLEN + 1);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] raw, input logic w);
        return w ? sext32(raw[31:0]) : raw;
    endfunction

    function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] pmag,
                                                input logic neg, input logic hi);
        logic [2*XLEN-1:0] p;
        p = neg ? -pmag : pmag;
        return hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
    endfunction

    mdu_state_e state_q, state_d;
    logic       accept;

    // ---------------- decode ----------------
    mdu_op_e op_d;
    logic    d_mul, d_hi, d_w, d_rem, d_s1, d_s2;

    always_comb begin
        op_d  = (in_op <= 4'(REMUW)) ? mdu_op_e'(in_op) : MUL;
        d_mul = 1'b0; d_hi = 1'b0; d_w = 1'b0; d_rem = 1'b0; d_s1 = 1'b0; d_s2 = 1'b0;
        case (op_d)
            MUL:    d_mul = 1'b1;
            MULH:   begin d_mul = 1'b1; d_hi = 1'b1; d_s1 = 1'b1; d_s2 = 1'b1; end
            MULHSU: begin d_mul = 1'b1; d_hi = 1'b1; d_s1 = 1'b1; end
            MULHU:  begin d_mul = 1'b1; d_hi = 1'b1; end
            DIV:    begin d_s1 = 1'b1; d_s2 = 1'b1; end
            DIVU:   ;
            REM:    begin d_rem = 1'b1; d_s1 = 1'b1; d_s2 = 1'b1; end
            REMU:   d_rem = 1'b1;
            MULW:   begin d_mul = 1'b1; d_w = 1'b1; end
            DIVW:   begin d_w = 1'b1; d_s1 = 1'b1; d_s2 = 1'b1; end
            DIVUW:  d_w = 1'b1;
            REMW:   begin d_w = 1'b1; d_rem = 1'b1; d_s1 = 1'b1; d_s2 = 1'b1; end
            REMUW:  begin d_w = 1'b1; d_rem = 1'b1; end
            default: d_mul = 1'b1;
        endcase
    end

    // ---------------- operand preparation ----------------
    // W ops are widened to XLEN first so one magnitude/sign path serves both widths;
    // the magnitude of a sign-extended 32-bit value still fits in 32 bits.
    logic [XLEN-1:0] opa, opb, mag1, mag2;
    logic            neg1, neg2, div0, ovf, fast_mul, fast_go;
    logic [XLEN-1:0] fast_raw;

    always_comb begin
        opa  = d_w ? (d_s1 ? sext32(in_src1[31:0]) : XLEN'(in_src1[31:0])) : in_src1;
        opb  = d_w ? (d_s2 ? sext32(in_src2[31:0]) : XLEN'(in_src2[31:0])) : in_src2;
        neg1 = d_s1 & opa[XLEN-1];
        neg2 = d_s2 & opb[XLEN-1];
        mag1 = neg1 ? -opa : opa;
        mag2 = neg2 ? -opb : opb;
        div0 = ~d_mul & (opb == '0);
        ovf  = ~d_mul & d_s1 &
               (d_w ? ((in_src1[31:0] == 32'h8000_0000) & (in_src2[31:0] == '1))
                    : ((in_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (in_src2 == '1)));
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_fast;
    assign prod_fast = (2*XLEN)'(mag1) * (2*XLEN)'(mag2);
    assign fast_mul  = d_mul;
`else
    assign fast_mul  = 1'b0;
`endif

    assign fast_go = div0 | ovf | fast_mul;

    always_comb begin
        fast_raw = '0;
        if (div0)
            fast_raw = d_rem ? opa : '1;
        else if (ovf)
            fast_raw = d_rem ? '0 : opa;
`ifdef MDU_FAST_MUL_EN
        else if (d_mul)
            fast_raw = mul_sel(prod_fast, neg1 ^ neg2, d_hi);
`endif
    end

    // ---------------- datapath state ----------------
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q, mcand_q;
    logic [XLEN-1:0]   mplier_q, fast_res_q;
    logic [TAG_W-1:0]  tag_q;
    logic              mul_q, hi_q, w_q, rem_op_q, neg_q, neg1_q, fast_q;
    logic [XLEN-1:0]   dquo, drem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            fast_res_q <= '0;
            tag_q      <= '0;
            mul_q      <= 1'b0;
            hi_q       <= 1'b0;
            w_q        <= 1'b0;
            rem_op_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg1_q     <= 1'b0;
            fast_q     <= 1'b0;
        end else if (accept) begin
            cnt_q      <= d_w ? CW'(MDU_W_LEN) : CW'(XLEN);
            acc_q      <= '0;
            mcand_q    <= (2*XLEN)'(mag1);
            mplier_q   <= mag2;
            fast_res_q <= wfix(fast_raw, d_w);
            tag_q      <= in_tag;
            mul_q      <= d_mul;
            hi_q       <= d_hi;
            w_q        <= d_w;
            rem_op_q   <= d_rem;
            neg_q      <= neg1 ^ neg2;
            neg1_q     <= neg1;
            fast_q     <= fast_go;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q - CW'(1);
            if (mul_q) begin
                if (mplier_q[0])
                    acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

    // W-op dividends are pre-shifted so the divider always consumes from its MSB.
    ysyx_22050612_mdu_divcore #(.XLEN(XLEN)) u_divcore (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept),
        .step     ((state_q == CALC) & ~mul_q),
        .dividend (d_w ? (mag1 << (XLEN - MDU_W_LEN)) : mag1),
        .divisor  (mag2),
        .quo      (dquo),
        .rem      (drem)
    );

    logic [XLEN-1:0] calc_raw, final_res;

    always_comb begin
        if (mul_q)
            calc_raw = mul_sel(acc_q, neg_q, hi_q);
        else if (rem_op_q)
            calc_raw = neg1_q ? -drem : drem;
        else
            calc_raw = neg_q ? -dquo : dquo;
        final_res = fast_q ? fast_res_q : wfix(calc_raw, w_q);
    end

    // ---------------- FSM ----------------
    assign accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    if (accept) state_d = fast_go ? DONE : CALC;
                CALC:    if (cnt_q == CW'(1)) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE) & rst_n;
        out_valid  = (state_q == DONE);
        out_result = out_valid ? final_res : '0;
        out_tag    = out_valid ? tag_q : '0;
    end

endmodule

// File: tb/tb_ysyx_22050612_mdu.sv
// Directed, table-driven bench for ysyx_22050612_mdu (XLEN=64, TAG_W=5).
// Checks result, tag and handshake latency per op, then hand sequences for hold, flush, reset.
// Drives on negedge / #1 after posedge; samples on negedge.
module tb_ysyx_22050612_mdu;
    import ysyx_22050612_mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int ML64 = 1;
    localparam int ML32 = 1;
`else
    localparam int ML64 = 65;
    localparam int ML32 = 33;
`endif
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_op;
    logic [63:0] in_src1, in_src2, out_result;
    logic [4:0]  in_tag, out_tag;

    always #5 clk = ~clk;

    ysyx_22050612_mdu #(.XLEN(64), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    typedef struct {
        logic [3:0]  op;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [4:0]  tag;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[20];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] s1, input logic [63:0] s2,
                         input logic [4:0] tag);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2; in_tag = tag;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
        issue(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].tag);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 300);
        check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
        check($sformatf("v%0d result", i), out_result, vecs[i].exp);
        check($sformatf("v%0d tag", i), 64'(out_tag), 64'(vecs[i].tag));
        if (out_valid) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end else begin
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vecs[0]  = '{DIVU,   64'd100, 64'd7, 5'd3, 64'd14, 65};
        vecs[1]  = '{REMU,   64'd100, 64'd7, 5'd4, 64'd2, 65};
        vecs[2]  = '{DIV,    -64'sd7, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[3]  = '{REM,    -64'sd7, 64'd2, 5'd6, ALL1, 65};
        vecs[4]  = '{DIVW,   64'hFFFF_FFFF_8000_0000, ALL1, 5'd7, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[5]  = '{DIVU,   64'h1234, 64'd0, 5'd8, ALL1, 1};
        vecs[6]  = '{REMU,   64'h1234, 64'd0, 5'd9, 64'h1234, 1};
        vecs[7]  = '{MULH,   64'h8000_0000_0000_0000, 64'd2, 5'd10, ALL1, ML64};
        vecs[8]  = '{MULW,   64'h7FFF_FFFF, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFE, ML32};
        vecs[9]  = '{MUL,    64'h1234_5678, 64'h1000, 5'd12, 64'h123_4567_8000, ML64};
        vecs[10] = '{MULHU,  ALL1, ALL1, 5'd13, 64'hFFFF_FFFF_FFFF_FFFE, ML64};
        vecs[11] = '{MULHSU, ALL1, 64'd2, 5'd14, ALL1, ML64};
        vecs[12] = '{DIVUW,  64'h1_0000_0064, 64'd7, 5'd15, 64'd14, 33};
        vecs[13] = '{REMW,   -64'sd7, 64'd2, 5'd16, ALL1, 33};
        vecs[14] = '{DIV,    64'h8000_0000_0000_0000, ALL1, 5'd17, 64'h8000_0000_0000_0000, 1};
        vecs[15] = '{REM,    64'h8000_0000_0000_0000, ALL1, 5'd18, 64'd0, 1};
        vecs[16] = '{4'd15,  64'd3, 64'd5, 5'd19, 64'd15, ML64};
        vecs[17] = '{REMW,   64'h8000_0000, 64'hFFFF_FFFF_0000_0000, 5'd20, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[18] = '{REMUW,  64'h1_0000_0005, 64'd3, 5'd21, 64'd2, 33};
        vecs[19] = '{DIVW,   64'hFFFF_FFF9, 64'd2, 5'd22, 64'hFFFF_FFFF_FFFF_FFFD, 33};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 4'd0; in_src1 = '0; in_src2 = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_result", out_result, 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        #1 check("post-reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 20; i++) run_vec(i);

        // Result held in DONE while out_ready is low; no new request accepted.
        issue(DIVU, 64'd100, 64'd7, 5'd9);
        seen = 0;
        do begin
            @(negedge clk);
            seen++;
        end while (!out_valid && seen < 300);
        check("hold first valid", 64'(out_valid), 64'd1);
        in_valid = 1'b1; in_op = DIV; in_src1 = 64'd5; in_src2 = 64'd0; in_tag = 5'd30;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d valid", k), 64'(out_valid), 64'd1);
            check($sformatf("hold%0d result", k), out_result, 64'd14);
            check($sformatf("hold%0d tag", k), 64'(out_tag), 64'd9);
            check($sformatf("hold%0d in_ready", k), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("release valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("after release valid", 64'(out_valid), 64'd0);
        check("after release in_ready", 64'(in_ready), 64'd1);

        // Flush 10 cycles into a divide: back to IDLE, no result ever appears.
        issue(DIV, -64'sd100, 64'd7, 5'd1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush in_ready", 64'(in_ready), 64'd1);
        check("flush out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush no result", 64'(seen), 64'd0);

        // Reset during CALC: outputs zero, in_ready low in reset, op discarded.
        issue(DIVU, 64'd1000, 64'd3, 5'd2);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid-reset out_valid", 64'(out_valid), 64'd0);
        check("mid-reset out_result", out_result, 64'd0);
        check("mid-reset out_tag", 64'(out_tag), 64'd0);
        check("mid-reset in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("reset no result", 64'(seen), 64'd0);
        check("reset idle in_ready", 64'(in_ready), 64'd1);

        // Unit is usable again after flush/reset.
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
